imu_burst_sampler: RTL
======================

IMU_BURST_SAMPLER -- requirements
Module: imu_burst_sampler

Interface
REQ-001 Parameter NUM_CH, default 6, number of 16-bit sensor channels per frame (1..16).
REQ-002 Parameter FIFO_FRAMES, default 4, FIFO capacity in whole frames (power of 2, >=2).
REQ-003 Parameter PERIOD_W, default 16, width of sample-period counter.
REQ-004 Parameter MAX_RETRY, default 2, re-attempts per byte after NACK.
REQ-005 clk  in  1  clock; reset  in  1  reset, synchronous, active-high.
REQ-006 enable  in  1  level; 1 = sampling permitted.
REQ-007 continuous  in  1  1 = periodic frames, 0 = one frame per start pulse.
REQ-008 start  in  1  single-cycle pulse; triggers one frame when continuous=0.
REQ-009 period  in  PERIOD_W  clk cycles between frame starts in continuous mode.
REQ-010 ch_addr  in  NUM_CH*8  MSB register address of channel i at bits [8i+7:8i]; LSB address = MSB+1 mod 256.
REQ-011 rd_req  out  1 / rd_addr  out  8  byte-read request to I2C byte master; held until rd_done or rd_err.
REQ-012 rd_done  in  1 / rd_err  in  1 / rd_data  in  8  single-cycle completion (data valid) or NACK.
REQ-013 m_valid  out  1 / m_ready  in  1 / m_data  out  16 / m_ch  out  4 / m_last  out  1  output word stream.
REQ-014 busy  out  1; err_sticky  out  1; drop_cnt  out  8.

Function
REQ-015 States: IDLE, WAIT_TRIG, REQ_MSB, REQ_LSB, COMMIT; busy=1 in REQ_MSB/REQ_LSB/COMMIT.
REQ-016 IDLE -> WAIT_TRIG when enable=1; any state -> IDLE when enable=0, except COMMIT completes first; a partial frame is discarded without a drop count.
REQ-017 WAIT_TRIG -> REQ_MSB (channel 0) on start (continuous=0) or period counter expiry (continuous=1).
REQ-018 Period counter reloads with period at each frame start and counts every cycle; period=0 treated as 1; an expiry while busy is held pending and starts the next frame on return to WAIT_TRIG, so back-to-back frames lose no trigger; multiple pending expiries collapse to one.
REQ-019 start pulses arriving while busy are ignored.
REQ-020 REQ_MSB: rd_req=1, rd_addr=ch_addr[ch]; on rd_done capture rd_data into word[15:8] and go to REQ_LSB; REQ_LSB: rd_addr=MSB+1, on rd_done capture word[7:0].
REQ-021 After LSB of channel NUM_CH-1 -> COMMIT; otherwise next channel REQ_MSB; rd_req deasserts for exactly one cycle between bytes.
REQ-022 On rd_err, re-request the same byte; after MAX_RETRY failed retries set err_sticky, abandon frame, increment drop_cnt, return to WAIT_TRIG.
REQ-023 COMMIT: if FIFO free space >= NUM_CH words, write the NUM_CH assembled words, one per cycle, ch 0 first; else drop the frame, increment drop_cnt.
REQ-024 drop_cnt saturates at 255; err_sticky cleared only by reset.
REQ-025 FIFO depth FIFO_FRAMES*NUM_CH words, each entry {ch, data}; m_last=1 on channel NUM_CH-1.
REQ-026 m_valid=1 whenever FIFO non-empty; word pops on m_valid&m_ready; m_data/m_ch/m_last stable while m_valid=1 and m_ready=0.
REQ-027 Simultaneous FIFO write and pop in one cycle permitted, including when full; occupancy unchanged.
REQ-028 First word of a committed frame appears on m_valid no earlier than 1 cycle after its write.

Reset
REQ-029 On reset: state IDLE, rd_req=0, rd_addr=0, m_valid=0, FIFO empty, busy=0, err_sticky=0, drop_cnt=0, period counter and pending flag cleared.
REQ-030 Reset mid-frame or mid-COMMIT discards all partial data; no word emitted after reset deasserts until a new frame commits.

Verification
REQ-031 NUM_CH=6, continuous=0, start pulse, model returns MSB=8'h12,LSB=8'h34 for ch0 -> rd_addr sequence ch_addr[0],+1,...; m_data=16'h1234, m_ch=0; m_last only on ch5.
REQ-032 continuous=1, period=100, m_ready=1 -> frame starts every 100 clk while bus latency < 100; no missed frame when latency > 100 (pending trigger used).
REQ-033 Model NACKs ch2 MSB 3 times (MAX_RETRY=2) -> err_sticky=1, drop_cnt=1, no words of that frame emitted, next frame normal.
REQ-034 m_ready=0, 5 frames with FIFO_FRAMES=4 -> 24 words held, drop_cnt=1; then m_ready=1 -> 24 words in order, first four frames only.
REQ-035 m_ready toggled every cycle during COMMIT -> no word lost/duplicated, outputs stable while stalled.
REQ-036 reset asserted during REQ_LSB of ch3 -> all outputs at reset values next cycle; next frame emits 6 fresh words only.

Source files
------------

// File: rtl/imu_burst_sampler.sv
// IMU burst sampler: reads NUM_CH 16-bit channels as MSB/LSB byte pairs over an
// I2C byte master and commits whole frames into a word FIFO for streaming out.
//
// state     | meaning
// IDLE      | sampling disabled
// WAIT_TRIG | armed, waiting for start pulse or period expiry
// REQ_MSB   | reading MSB byte of channel ch
// REQ_LSB   | reading LSB byte of channel ch
// COMMIT    | writing assembled frame into FIFO (or dropping it)
module imu_burst_sampler #(
  parameter int NUM_CH      = 6,
  parameter int FIFO_FRAMES = 4,
  parameter int PERIOD_W    = 16,
  parameter int MAX_RETRY   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  continuous,
  input  logic                  start,
  input  logic [PERIOD_W-1:0]   period,
  input  logic [NUM_CH*8-1:0]   ch_addr,
  output logic                  rd_req,
  output logic [7:0]            rd_addr,
  input  logic                  rd_done,
  input  logic                  rd_err,
  input  logic [7:0]            rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [15:0]           m_data,
  output logic [3:0]            m_ch,
  output logic                  m_last,
  output logic                  busy,
  output logic                  err_sticky,
  output logic [7:0]            drop_cnt
);

  localparam int DEPTH = FIFO_FRAMES * NUM_CH;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int RW    = $clog2(MAX_RETRY + 2);
  localparam logic [3:0]    LAST_CH  = 4'(NUM_CH - 1);
  localparam logic [CW-1:0] FULL_LIM = CW'(DEPTH - NUM_CH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  typedef enum logic [2:0] {IDLE, WAIT_TRIG, REQ_MSB, REQ_LSB, COMMIT} state_t;

  state_t              state, state_nxt;
  logic [3:0]          ch;
  logic                gap;
  logic [RW-1:0]       retry;
  logic [15:0]         words [NUM_CH];
  logic [PERIOD_W-1:0] per_cnt, per_eff;
  logic                pend, trig;
  logic [19:0]         mem [DEPTH];
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       count;
  logic [7:0]          cur_addr;
  logic [15:0]         wr_word;
  logic                in_req, byte_ok, byte_err;
  logic                frame_start, fifo_wr, fifo_rd, drop, abandon;

  always_comb begin
    cur_addr = 8'h00;
    wr_word  = 16'h0000;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch == 4'(i)) begin
        cur_addr = ch_addr[8*i +: 8];
        wr_word  = words[i];
      end
    end
  end

  assign in_req   = (state == REQ_MSB) || (state == REQ_LSB);
  assign rd_req   = in_req && !gap;
  assign rd_addr  = (state == REQ_MSB) ? cur_addr :
                    (state == REQ_LSB) ? cur_addr + 8'd1 : 8'h00;
  assign byte_ok  = rd_req && rd_done;
  assign byte_err = rd_req && rd_err && !rd_done;
  assign per_eff  = (period == '0) ? PERIOD_W'(1) : period;
  // An expired counter stays at zero, so a trigger missed while busy fires on return.
  assign trig     = continuous ? (pend || per_cnt <= PERIOD_W'(1)) : start;

  always_comb begin
    state_nxt   = state;
    busy        = 1'b0;
    frame_start = 1'b0;
    fifo_wr     = 1'b0;
    drop        = 1'b0;
    abandon     = 1'b0;
    case (state)
      IDLE: if (enable) state_nxt = WAIT_TRIG;
      WAIT_TRIG: begin
        if (!enable) state_nxt = IDLE;
        else if (trig) begin
          state_nxt   = REQ_MSB;
          frame_start = 1'b1;
        end
      end
      REQ_MSB, REQ_LSB: begin
        busy = 1'b1;
        if (!enable) state_nxt = IDLE;
        else if (byte_ok) begin
          if (state == REQ_MSB)    state_nxt = REQ_LSB;
          else if (ch == LAST_CH)  state_nxt = COMMIT;
          else                     state_nxt = REQ_MSB;
        end else if (byte_err && retry == RW'(MAX_RETRY)) begin
          abandon   = 1'b1;
          drop      = 1'b1;
          state_nxt = WAIT_TRIG;
        end
      end
      COMMIT: begin
        busy = 1'b1;
        if (ch == 4'd0 && count > FULL_LIM) begin
          drop      = 1'b1;
          state_nxt = enable ? WAIT_TRIG : IDLE;
        end else begin
          fifo_wr = 1'b1;
          if (ch == LAST_CH) state_nxt = enable ? WAIT_TRIG : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ch         <= 4'd0;
      gap        <= 1'b0;
      retry      <= '0;
      per_cnt    <= '0;
      pend       <= 1'b0;
      err_sticky <= 1'b0;
      drop_cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      gap   <= (byte_ok || byte_err) &&
               (state_nxt == REQ_MSB || state_nxt == REQ_LSB);
      if (frame_start || byte_ok) retry <= '0;
      else if (byte_err)          retry <= retry + 1'b1;
      if (frame_start)
        ch <= 4'd0;
      else if ((byte_ok && state == REQ_LSB) || fifo_wr)
        ch <= (ch == LAST_CH) ? 4'd0 : ch + 4'd1;
      if (frame_start)          per_cnt <= per_eff;
      else if (per_cnt != '0)   per_cnt <= per_cnt - 1'b1;
      if (frame_start) pend <= 1'b0;
      else if (continuous && per_cnt == PERIOD_W'(1) && state != WAIT_TRIG) pend <= 1'b1;
      if (abandon) err_sticky <= 1'b1;
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (byte_ok && ch == 4'(i)) begin
        if (state == REQ_MSB) words[i][15:8] <= rd_data;
        else                  words[i][7:0]  <= rd_data;
      end
    end
  end

  assign fifo_rd = m_valid && m_ready;
  assign m_valid = (count != '0);
  assign {m_ch, m_data} = mem[rd_ptr];
  assign m_last  = (m_ch == LAST_CH);

  always_ff @(posedge clk) begin
    if (fifo_wr) mem[wr_ptr] <= {ch, wr_word};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (fifo_wr) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (fifo_rd) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      case ({fifo_wr, fifo_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
